// File: rtl/spi_reg_ctrl_pkg.sv
// spi_reg_ctrl shared types.
// Command codes and FSM states.
package spi_reg_ctrl_pkg;

  typedef enum logic [7:0] {
    CMD_ADDR = 8'h2a,
    CMD_WR   = 8'h3a,
    CMD_RD   = 8'h3b
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } state_t;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-stream in, register-file strobes out.
// slave = decoder side, master = stream/regfile side.
interface spi_reg_ctrl_if #(
  parameter int REG_NUM   = 8,
  parameter int REG_WIDTH = 32
);
  localparam int AW = $clog2(REG_NUM);
  localparam int NB = REG_WIDTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  logic                 dc_i;
  logic                 spi_byte_vld_i;
  logic [7:0]           spi_byte_data_i;
  logic                 reg_rd_en_o;
  logic [AW-1:0]        reg_rd_addr_o;
  logic [BW-1:0]        reg_rd_byte_o;
  logic                 reg_wr_en_o;
  logic [AW-1:0]        reg_wr_addr_o;
  logic [REG_WIDTH-1:0] reg_wr_data_o;
  logic                 err_o;

  modport slave (
    input  dc_i, spi_byte_vld_i, spi_byte_data_i,
    output reg_rd_en_o, reg_rd_addr_o, reg_rd_byte_o,
    output reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o,
    output err_o
  );

  modport master (
    output dc_i, spi_byte_vld_i, spi_byte_data_i,
    input  reg_rd_en_o, reg_rd_addr_o, reg_rd_byte_o,
    input  reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o,
    input  err_o
  );
endinterface

// File: rtl/spi_reg_ptr.sv
// Register pointer and byte-lane counter.
// Load from base, step per byte, wrap or stop at the top.
module spi_reg_ptr #(
  parameter int REG_NUM = 8,
  parameter int NB      = 4,
  parameter int WRAP_EN = 1,
  parameter int AW      = 3,
  parameter int BW      = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          clr_i,
  input  logic          step_i,
  input  logic [AW-1:0] base_i,
  output logic [AW-1:0] ptr_o,
  output logic [BW-1:0] idx_o,
  output logic          last_o,
  output logic          end_o
);

  logic [AW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] idx_q, idx_d;
  logic          at_top;

  assign at_top = (ptr_q == AW'(REG_NUM - 1));
  assign last_o = (idx_q == BW'(NB - 1));
  assign end_o  = last_o & at_top & (WRAP_EN == 0);
  assign ptr_o  = ptr_q;
  assign idx_o  = idx_q;

  // Next pointer/index: load, clear, or advance one byte.
  always_comb begin
    ptr_d = ptr_q;
    idx_d = idx_q;
    if (load_i) ptr_d = base_i;
    if (clr_i) begin
      idx_d = '0;
    end else if (step_i) begin
      if (last_o) begin
        idx_d = '0;
        if (!at_top)          ptr_d = ptr_q + 1'b1;
        else if (WRAP_EN != 0) ptr_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Pointer/index state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      idx_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command/data decoder for a register file.
// Read strobes per byte, assembled write words, auto-increment.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int REG_NUM   = 8,
  parameter int REG_WIDTH = 32,
  parameter int WRAP_EN   = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  spi_reg_ctrl_if.slave  bus
);

  localparam int AW = $clog2(REG_NUM);
  localparam int NB = REG_WIDTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  state_t               state_q, state_d;
  logic [AW-1:0]        base_q, base_d;
  logic [REG_WIDTH-1:0] shift_q, shift_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [REG_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                 err_q, err_d;

  logic          cmd_vld, dat_vld;
  logic          load, clr, step;
  logic [AW-1:0] ptr;
  logic [BW-1:0] idx;
  logic          last, at_end;
  logic [7:0]    byte_in;

  assign byte_in = bus.spi_byte_data_i;
  assign cmd_vld = bus.spi_byte_vld_i & ~bus.dc_i;
  assign dat_vld = bus.spi_byte_vld_i & bus.dc_i;

  spi_reg_ptr #(
    .REG_NUM (REG_NUM),
    .NB      (NB),
    .WRAP_EN (WRAP_EN),
    .AW      (AW),
    .BW      (BW)
  ) u_ptr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .clr_i  (clr),
    .step_i (step),
    .base_i (base_q),
    .ptr_o  (ptr),
    .idx_o  (idx),
    .last_o (last),
    .end_o  (at_end)
  );

  assign bus.reg_rd_en_o   = (state_q == RD) & dat_vld;
  assign bus.reg_rd_addr_o = ptr;
  assign bus.reg_rd_byte_o = idx;
  assign bus.reg_wr_en_o   = wr_en_q;
  assign bus.reg_wr_addr_o = wr_addr_q;
  assign bus.reg_wr_data_o = wr_data_q;
  assign bus.err_o         = err_q;

  // Decode commands and data bytes into next state and outputs.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    shift_d   = shift_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    load      = 1'b0;
    clr       = 1'b0;
    step      = 1'b0;
    if (cmd_vld) begin
      clr     = 1'b1;
      shift_d = '0;
      case (byte_in)
        CMD_RD: begin
          state_d = RD;
          load    = 1'b1;
        end
        CMD_WR: begin
          state_d = WR;
          load    = 1'b1;
        end
        CMD_ADDR: state_d = ADDR;
        default: begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      endcase
    end else if (dat_vld) begin
      case (state_q)
        ADDR: begin
          if (int'(byte_in) < REG_NUM) base_d = AW'(byte_in);
          else                         err_d  = 1'b1;
          state_d = IDLE;
        end
        RD: begin
          step = 1'b1;
          if (at_end) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        WR: begin
          step    = 1'b1;
          shift_d = (shift_q << 8) | REG_WIDTH'(byte_in);
          if (last) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr;
            wr_data_d = shift_d;
          end
          if (at_end) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, base, shift register and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      shift_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      shift_q   <= shift_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

endmodule
